// File: rtl/rm_ihpsg13_2p_fifo_ctrl.sv
// rm_ihpsg13_2p_fifo_ctrl: single-clock first-word-fall-through FIFO controller
// for one RM_IHPSG13_2P_* two-port SRAM macro. Port A pushes, port B pops.
// A 2-entry output buffer hides the macro's 1-cycle read latency.
// Optional synchronous FLUSH input: define RM_IHPSG13_FIFO_FLUSH_EN.
`timescale 1ns/1ps

module rm_ihpsg13_2p_fifo_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned LVL_W  = 7
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef RM_IHPSG13_FIFO_FLUSH_EN
  input  logic              FLUSH,
`endif
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [LVL_W-1:0]  LEVEL,
  output logic              A_MEN,
  output logic              A_WEN,
  output logic              A_REN,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DIN,
  output logic              A_DLY,
  output logic              B_MEN,
  output logic              B_WEN,
  output logic              B_REN,
  output logic [ADDR_W-1:0] B_ADDR,
  output logic              B_DLY,
  input  logic [DATA_W-1:0] B_DOUT
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                run;
  logic                flush_run;

  logic [ADDR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;
  logic                inflight_q;
  logic [1:0]          ob_cnt_q, ob_cnt_d;
  logic [DATA_W-1:0]   ob0_q, ob1_q, ob0_d, ob1_d;

  logic                wr_ready;
  logic                rd_valid;
  logic                push;
  logic                pop;
  logic                issue;
  logic                capture;
  logic [2:0]          occ;

`ifdef RM_IHPSG13_FIFO_FLUSH_EN
  assign flush_run = FLUSH && (state_q == ST_RUN);
`else
  assign flush_run = 1'b0;
`endif

  // Next state: leave INIT on the first edge after reset, then stay in RUN
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        state_d = ST_RUN;
        run     = !flush_run;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Handshakes, read issue and output-buffer next state
  always_comb begin
    wr_ready  = run && (mem_cnt_q < CNT_W'(DEPTH));
    push      = WR_VALID && wr_ready;
    rd_valid  = !flush_run && (ob_cnt_q != 2'd0);
    pop       = rd_valid && RD_READY;
    // Words that will occupy the buffer once the pending return lands
    occ       = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = run && (mem_cnt_q != '0) && (occ < 3'd2);
    capture   = inflight_q && !flush_run;
    mem_cnt_d = mem_cnt_q + CNT_W'(push) - CNT_W'(issue);

    ob0_d    = ob0_q;
    ob1_d    = ob1_q;
    ob_cnt_d = ob_cnt_q;
    if (pop) begin
      ob0_d    = ob1_q;
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    if (capture) begin
      if (ob_cnt_d == 2'd0) begin
        ob0_d = B_DOUT;
      end else begin
        ob1_d = B_DOUT;
      end
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers, occupancy counters and output buffer storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else if (flush_run) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + ADDR_W'(1);
      end
      if (issue) begin
        rptr_q <= rptr_q + ADDR_W'(1);
      end
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= issue;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

  assign WR_READY = wr_ready;
  assign RD_VALID = rd_valid;
  assign RD_DATA  = ob0_q;
  assign LEVEL    = LVL_W'(mem_cnt_q) + LVL_W'(inflight_q) + LVL_W'(ob_cnt_q);

  assign A_MEN    = push;
  assign A_WEN    = push;
  assign A_REN    = 1'b0;
  assign A_ADDR   = wptr_q;
  assign A_DIN    = WR_DATA;
  assign A_DLY    = 1'b1;

  assign B_MEN    = issue;
  assign B_WEN    = 1'b0;
  assign B_REN    = issue;
  assign B_ADDR   = rptr_q;
  assign B_DLY    = 1'b1;

endmodule

// File: tb/tb_rm_ihpsg13_2p_fifo_ctrl.sv
// Bench for rm_ihpsg13_2p_fifo_ctrl with a behavioural two-port SRAM model.
// Build with RM_IHPSG13_FIFO_FLUSH_EN defined to also exercise FLUSH.
`timescale 1ns/1ps

module tb_rm_ihpsg13_2p_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [6:0]  level;
  logic        a_men, a_wen, a_ren, a_dly;
  logic [5:0]  a_addr;
  logic [31:0] a_din;
  logic        b_men, b_wen, b_ren, b_dly;
  logic [5:0]  b_addr;
  logic [31:0] b_dout;
`ifdef RM_IHPSG13_FIFO_FLUSH_EN
  logic        flush;
`endif

  logic [31:0] mem [0:63];
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_fail;

  rm_ihpsg13_2p_fifo_ctrl dut (
    .CLK      (clk),
    .RST      (rst),
`ifdef RM_IHPSG13_FIFO_FLUSH_EN
    .FLUSH    (flush),
`endif
    .WR_VALID (wr_valid),
    .WR_READY (wr_ready),
    .WR_DATA  (wr_data),
    .RD_VALID (rd_valid),
    .RD_READY (rd_ready),
    .RD_DATA  (rd_data),
    .LEVEL    (level),
    .A_MEN    (a_men),
    .A_WEN    (a_wen),
    .A_REN    (a_ren),
    .A_ADDR   (a_addr),
    .A_DIN    (a_din),
    .A_DLY    (a_dly),
    .B_MEN    (b_men),
    .B_WEN    (b_wen),
    .B_REN    (b_ren),
    .B_ADDR   (b_addr),
    .B_DLY    (b_dly),
    .B_DOUT   (b_dout)
  );

  always #5 clk = ~clk;

  // Two-port SRAM model: write on A, registered read on B
  initial b_dout = '0;
  always @(posedge clk) begin
    if (a_men && a_wen) mem[a_addr] <= a_din;
    if (b_men && b_ren) b_dout <= mem[b_addr];
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a_men, a_wen, b_men, b_ren, rd_valid, wr_ready} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_enables: got %b expected 000000", {a_men, a_wen, b_men, b_ren, rd_valid, wr_ready});
      end
      n_checks++;
      if (level !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_level: got %0d expected 0", level);
      end
    end
    step();
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL init_wr_ready: got %b expected 0", wr_ready);
    end
    n_checks++;
    if ({a_ren, b_wen, a_dly, b_dly} !== 4'b0011) begin
      n_fail++;
      $display("FAIL const_ctrl: got %b expected 0011", {a_ren, b_wen, a_dly, b_dly});
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({wr_ready, rd_valid, level} !== {1'b1, 1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL run_idle: got rdy=%b vld=%b lvl=%0d expected rdy=1 vld=0 lvl=0", wr_ready, rd_valid, level);
    end
    step();
  endtask

  task automatic test_single();
    // Pop request while empty must be ignored
    rd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b_ren, rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL empty_pop: got ren=%b vld=%b expected 0 0", b_ren, rd_valid);
    end
    step();
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({wr_ready, level} !== {1'b1, 7'd0}) begin
      n_fail++;
      $display("FAIL single_pre: got rdy=%b lvl=%0d expected rdy=1 lvl=0", wr_ready, level);
    end
    step();
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_valid, level} !== {(k == 2), 7'd1}) begin
        n_fail++;
        $display("FAIL single_latency%0d: got vld=%b lvl=%0d expected vld=%0d lvl=1", k, rd_valid, level, (k == 2));
      end
      if (k < 2) step();
    end
    n_checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_data: got %h expected deadbeef", rd_data);
    end
    step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_valid, level} !== {1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL single_drain: got vld=%b lvl=%0d expected 0 0", rd_valid, level);
    end
    step();
  endtask

  task automatic test_full();
    rd_ready = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i);
      @(negedge clk);
      n_checks++;
      if ({wr_ready, level} !== {1'b1, 7'(i - 1)}) begin
        n_fail++;
        $display("FAIL fill_%0d: got rdy=%b lvl=%0d expected rdy=1 lvl=%0d", i, wr_ready, level, i - 1);
      end
      step();
    end
    wr_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_ready, a_men, level, rd_valid} !== {1'b0, 1'b0, 7'd66, 1'b1}) begin
        n_fail++;
        $display("FAIL full_hold: got rdy=%b amen=%b lvl=%0d vld=%b expected 0 0 66 1", wr_ready, a_men, level, rd_valid);
      end
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, 32'(k)}) begin
        n_fail++;
        $display("FAIL full_pop_%0d: got vld=%b data=%h expected vld=1 data=%h", k, rd_valid, rd_data, 32'(k));
      end
      step();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_valid, level} !== {1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL full_empty: got vld=%b lvl=%0d expected 0 0", rd_valid, level);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int          pops = 0;
    logic [31:0] d = 32'h0000_1000;
    logic [31:0] e;
    rd_ready = 1'b1;
    for (int c = 0; c < 215; c++) begin
      wr_valid = (c < 200); wr_data = d;
      @(negedge clk);
      n_checks++;
      if (level !== 7'(exp_q.size())) begin
        n_fail++;
        $display("FAIL b2b_level_c%0d: got %0d expected %0d", c, level, exp_q.size());
      end
      n_checks++;
      if (rd_valid !== ((c >= 3) && (c < 203))) begin
        n_fail++;
        $display("FAIL b2b_valid_c%0d: got %b expected %0d", c, rd_valid, ((c >= 3) && (c < 203)));
      end
      if (c < 200) begin
        n_checks++;
        if (wr_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_c%0d: got %b expected 1", c, wr_ready);
        end
      end
      if (rd_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        n_checks++;
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL b2b_data_c%0d: got %h expected %h", c, rd_data, e);
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(d);
      step();
      d = d + 32'd1;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_checks++;
    if (pops != 200 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got pops=%0d left=%0d expected pops=200 left=0", pops, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random_stall();
    int          rd_out = 0;
    int          pop_i;
    logic [31:0] d = 32'hA000_0000;
    logic [31:0] e;
    for (int c = 0; c < 600; c++) begin
      if (c >= 300 && exp_q.size() == 0) break;
      wr_valid = (c < 300); wr_data = d;
      rd_ready = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      pop_i = (rd_valid && rd_ready) ? 1 : 0;
      n_checks++;
      if (level !== 7'(exp_q.size())) begin
        n_fail++;
        $display("FAIL rnd_level_c%0d: got %0d expected %0d", c, level, exp_q.size());
      end
      n_checks++;
      if (b_ren === 1'b1 && (rd_out - pop_i) >= 2) begin
        n_fail++;
        $display("FAIL rnd_overissue_c%0d: got ren=1 with outstanding=%0d expected ren=0", c, rd_out - pop_i);
      end
      if (pop_i == 1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_dup_c%0d: got data=%h expected no valid word", c, rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            n_fail++;
            $display("FAIL rnd_data_c%0d: got %h expected %h", c, rd_data, e);
          end
        end
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(d);
        d = d + 32'd1;
      end
      rd_out = rd_out + (b_ren ? 1 : 0) - pop_i;
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || rd_out != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got left=%0d outstanding=%0d expected 0 0", exp_q.size(), rd_out);
    end
    exp_q.delete();
  endtask

`ifdef RM_IHPSG13_FIFO_FLUSH_EN
  task automatic test_flush();
    flush = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wr_valid = 1'b1; wr_data = 32'h100 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();
    rd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b_ren, rd_data} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL flush_pre_pop: got ren=%b data=%h expected 1 00000100", b_ren, rd_data);
    end
    step();
    rd_ready = 1'b0; flush = 1'b1; wr_valid = 1'b1; wr_data = 32'hBAD;
    @(negedge clk);
    n_checks++;
    if ({level, rd_valid, wr_ready, a_men, b_men} !== {7'd10, 4'b0000}) begin
      n_fail++;
      $display("FAIL flush_cycle: got lvl=%0d vld=%b rdy=%b amen=%b bmen=%b expected 10 0 0 0 0", level, rd_valid, wr_ready, a_men, b_men);
    end
    step();
    flush = 1'b0; wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({level, rd_valid} !== {7'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL flush_after%0d: got lvl=%0d vld=%b expected 0 0", k, level, rd_valid);
      end
      step();
    end
    wr_valid = 1'b1; wr_data = 32'h5;
    step();
    wr_valid = 1'b0;
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({rd_valid, rd_data, level} !== {1'b1, 32'h5, 7'd1}) begin
      n_fail++;
      $display("FAIL flush_repush: got vld=%b data=%h lvl=%0d expected 1 00000005 1", rd_valid, rd_data, level);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
`ifdef RM_IHPSG13_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random_stall();
`ifdef RM_IHPSG13_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
